// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked instruction decoder feeding EX.
// Holds one decoded control word, owns the architectural sc flag, resolves
// branches against the registered sc and stalls fetch while a multi-cycle
// load completes in EX.
module decode_stage #(
  parameter int                 MCODEBITS = 9,
  parameter int                 OPWIDTH   = 4,
  parameter int                 LUTW      = 4,
  parameter logic [OPWIDTH-1:0] ALU_NOP   = 4'b1001,
  parameter int                 LOAD_LAT  = 3
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 instr_valid,
  input  logic [MCODEBITS-1:0] instr,
  output logic                 instr_ready,
  input  logic                 ex_ready,
  input  logic                 sc_in,
  output logic                 ctrl_valid,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 loadMem,
  output logic                 storeMem,
  output logic                 regWrite,
  output logic                 movInstr,
  output logic                 immVal,
  output logic [1:0]           Branch,
  output logic [LUTW-1:0]      targetLUT,
  output logic                 sc,
  output logic                 take_branch,
  output logic                 flush
);

  // wait counter only has to hold LOAD_LAT-1
  localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  localparam logic [OPWIDTH-1:0] OP_MOV = OPWIDTH'(4'b1000);

  localparam logic [8:0] W_NOP = 9'b011010000;
  localparam logic [8:0] W_CLR = 9'b011011111;
  localparam logic [8:0] W_INV = 9'b011010011;

  typedef enum logic [1:0] {SC_KEEP, SC_CLR, SC_INV, SC_ALU} scop_t;
  typedef enum logic {RUN, LWAIT} state_t;

  typedef struct packed {
    logic [OPWIDTH-1:0] aluop;
    logic               ld;
    logic               st;
    logic               rw;
    logic               mv;
    logic               imm;
    logic [1:0]         br;
    logic [LUTW-1:0]    lut;
    scop_t              scop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    aluop: ALU_NOP, ld: 1'b0, st: 1'b0, rw: 1'b0, mv: 1'b0, imm: 1'b0,
    br: 2'b00, lut: '0, scop: SC_KEEP
  };

  // ISA table, first match wins; sc side effects are carried along and
  // applied only when the word actually issues
  function automatic ctrl_t decode(input logic [8:0] d, input logic [LUTW-1:0] idx);
    ctrl_t c;
    c = CTRL_NOP;
    if (d[8]) begin
      c.aluop = OP_MOV;
      c.rw    = 1'b1;
      c.mv    = 1'b1;
    end else if (d == W_NOP) begin
      c = CTRL_NOP;
    end else if (d == W_CLR) begin
      c.scop = SC_CLR;
    end else if (d == W_INV) begin
      c.scop = SC_INV;
    end else if (d[8:7] == 2'b01) begin
      c.aluop = OPWIDTH'({1'b0, d[6:4]});
      c.rw    = 1'b1;
      // 0111xxxxx and 0100xxxxx are the flag-setting ALU groups
      if (d[6:5] == 2'b11 || d[6:5] == 2'b00) c.scop = SC_ALU;
    end else begin
      case (d[8:4])
        5'b00100: begin c.br = 2'b11; c.lut = idx; end
        5'b00101: begin c.br = 2'b01; c.lut = idx; end
        5'b00110: begin c.br = 2'b10; c.lut = idx; end
        5'b00111: begin c.aluop = OP_MOV; c.rw = 1'b1; c.imm = 1'b1; end
        5'b00010: begin c.ld = 1'b1; c.rw = 1'b1; end
        5'b00011: begin c.st = 1'b1; end
        default:  c = CTRL_NOP;
      endcase
    end
    return c;
  endfunction

  ctrl_t          cw;
  logic           vld_q;
  state_t         state;
  logic [CW-1:0]  cnt;
  logic           run;
  logic           issue;
  logic           accept;

  // a word accepted while a load issues is parked in cw and masked until RUN
  assign run         = (state == RUN);
  assign ctrl_valid  = vld_q & run;
  assign issue       = ctrl_valid & ex_ready;
  assign take_branch = issue & ((cw.br == 2'b11) |
                                ((cw.br == 2'b01) &  sc) |
                                ((cw.br == 2'b10) & ~sc));
  assign flush       = take_branch;
  assign instr_ready = run & (~ctrl_valid | ex_ready) & ~take_branch;
  assign accept      = instr_valid & instr_ready;

  assign ALUOp     = cw.aluop;
  assign loadMem   = cw.ld;
  assign storeMem  = cw.st;
  assign regWrite  = cw.rw;
  assign movInstr  = cw.mv;
  assign immVal    = cw.imm;
  assign Branch    = cw.br;
  assign targetLUT = cw.lut;

  // control register: load on accept, drop valid on a bare issue, else hold
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cw    <= CTRL_NOP;
      vld_q <= 1'b0;
    end else if (accept) begin
      cw    <= decode(instr[MCODEBITS-1 -: 9], instr[LUTW-1:0]);
      vld_q <= 1'b1;
    end else if (issue) begin
      vld_q <= 1'b0;
    end
  end

  // architectural sc flag, updated only by the issuing word
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sc <= 1'b0;
    end else if (issue) begin
      case (cw.scop)
        SC_CLR:  sc <= 1'b0;
        SC_INV:  sc <= ~sc;
        SC_ALU:  sc <= sc_in;
        default: sc <= sc;
      endcase
    end
  end

  // load-latency FSM: park for LOAD_LAT-1 cycles after a load issues
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (issue && cw.ld && (LOAD_LAT > 1)) begin
            state <= LWAIT;
            cnt   <= CW'(LOAD_LAT - 1);
          end
        end
        LWAIT: begin
          if (cnt == CW'(1)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: accepted words push their expected
// decode; a negedge monitor compares the presented control word, sc,
// branch resolution, load stall and instr_ready against a reference model.
module tb_decode_stage;

  localparam int LOAD_LAT = 3;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [8:0] instr = '0;
  logic       instr_ready;
  logic       ex_ready = 1'b0;
  logic       sc_in = 1'b0;
  logic       ctrl_valid;
  logic [3:0] ALUOp;
  logic       loadMem, storeMem, regWrite, movInstr, immVal;
  logic [1:0] Branch;
  logic [3:0] targetLUT;
  logic       sc, take_branch, flush;

  decode_stage #(
    .MCODEBITS(9), .OPWIDTH(4), .LUTW(4), .ALU_NOP(4'b1001), .LOAD_LAT(LOAD_LAT)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ex_ready(ex_ready), .sc_in(sc_in),
    .ctrl_valid(ctrl_valid), .ALUOp(ALUOp), .loadMem(loadMem), .storeMem(storeMem),
    .regWrite(regWrite), .movInstr(movInstr), .immVal(immVal), .Branch(Branch),
    .targetLUT(targetLUT), .sc(sc), .take_branch(take_branch), .flush(flush)
  );

  always #5 Clk = ~Clk;

  // expected effect of one word; scop: 0 keep, 1 clear, 2 invert, 3 from sc_in
  typedef struct {
    logic [3:0] aluop;
    logic       ld, st, rw, mv, imm;
    logic [1:0] br;
    logic [3:0] lut;
    int         scop;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   model_sc = 1'b0;
  int   stall_left = 0;
  int   takes = 0;
  logic [3:0] take_lut = '0;
  bit   acc_flag = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference decode written from the ISA table as ranges of the 9-bit value
  function automatic exp_t ref_decode(input logic [8:0] d);
    exp_t e;
    int   v, top4, top5;
    v    = int'(d);
    top4 = v / 32;
    top5 = v / 16;
    e = '{aluop: 4'b1001, ld: 0, st: 0, rw: 0, mv: 0, imm: 0, br: 2'b00, lut: 4'h0, scop: 0};
    if (v >= 256) begin
      e.aluop = 4'b1000; e.rw = 1; e.mv = 1;
    end else if (v == 'b011010000) begin
      e.scop = 0;
    end else if (v == 'b011011111) begin
      e.scop = 1;
    end else if (v == 'b011010011) begin
      e.scop = 2;
    end else if (v >= 128) begin
      e.aluop = 4'((v / 16) % 8); e.rw = 1;
      if (top4 == 7 || top4 == 4) e.scop = 3;
    end else if (top5 == 4) begin
      e.br = 2'b11; e.lut = 4'(v % 16);
    end else if (top5 == 5) begin
      e.br = 2'b01; e.lut = 4'(v % 16);
    end else if (top5 == 6) begin
      e.br = 2'b10; e.lut = 4'(v % 16);
    end else if (top5 == 7) begin
      e.aluop = 4'b1000; e.rw = 1; e.imm = 1;
    end else if (top5 == 2) begin
      e.ld = 1; e.rw = 1;
    end else if (top5 == 3) begin
      e.st = 1;
    end
    return e;
  endfunction

  function automatic logic [8:0] rand_word();
    logic [8:0] r;
    r = 9'($urandom);
    case ($urandom_range(0, 9))
      0: r[8] = 1'b1;
      1: r = 9'b011010000;
      2: r = 9'b011011111;
      3: r = 9'b011010011;
      4: r[8:5] = 4'b0111;
      5: r[8:5] = 4'b0100;
      6: r[8:7] = 2'b01;
      7: r[8:6] = 3'b001;
      8: r[8:5] = 4'b0001;
      default: r = r;
    endcase
    return r;
  endfunction

  // producer side of the scoreboard: every accepted word pushes its expectation
  always @(negedge Clk) begin
    #1;
    if (Reset_n && instr_valid && instr_ready) begin
      q.push_back(ref_decode(instr));
      acc_flag = 1'b1;
    end
  end

  // monitor: compares every cycle, pops on issue
  initial begin
    exp_t e;
    bit   exp_cv, exp_take;
    forever begin
      @(negedge Clk);
      if (take_branch) begin takes++; take_lut = targetLUT; end
      if (!Reset_n) begin
        q.delete();
        model_sc   = 1'b0;
        stall_left = 0;
        chk("rst ctrl_valid", 32'(ctrl_valid), 32'd0);
        chk("rst ALUOp", 32'(ALUOp), 32'h9);
        chk("rst sc", 32'(sc), 32'd0);
        chk("rst strobes", 32'({loadMem, storeMem, regWrite, movInstr, immVal, Branch, targetLUT}), 32'd0);
        chk("rst take_branch", 32'(take_branch), 32'd0);
        continue;
      end
      chk("sc", 32'(sc), 32'(model_sc));
      if (stall_left > 0) begin
        chk("stall ctrl_valid", 32'(ctrl_valid), 32'd0);
        chk("stall instr_ready", 32'(instr_ready), 32'd0);
        chk("stall take_branch", 32'(take_branch), 32'd0);
        stall_left--;
        continue;
      end
      exp_cv   = (q.size() > 0);
      exp_take = 1'b0;
      chk("ctrl_valid", 32'(ctrl_valid), 32'(exp_cv));
      if (exp_cv) begin
        e = q[0];
        chk("ctrl word", 32'({ALUOp, loadMem, storeMem, regWrite, movInstr, immVal, Branch}),
            32'({e.aluop, e.ld, e.st, e.rw, e.mv, e.imm, e.br}));
        if (e.br != 2'b00) chk("targetLUT", 32'(targetLUT), 32'(e.lut));
        if (ex_ready) begin
          exp_take = (e.br == 2'b11) || (e.br == 2'b01 && model_sc) || (e.br == 2'b10 && !model_sc);
          case (e.scop)
            1: model_sc = 1'b0;
            2: model_sc = ~model_sc;
            3: model_sc = sc_in;
            default: model_sc = model_sc;
          endcase
          if (e.ld && LOAD_LAT > 1) stall_left = LOAD_LAT - 1;
          void'(q.pop_front());
        end
      end
      chk("take_branch", 32'(take_branch), 32'(exp_take));
      chk("flush", 32'(flush), 32'(exp_take));
      chk("instr_ready", 32'(instr_ready), 32'((!exp_cv || ex_ready) && !exp_take));
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // offer one word until accepted; waited = cycles it was on the bus
  task automatic send(input logic [8:0] w, output int waited);
    instr_valid = 1'b1;
    instr       = w;
    acc_flag    = 1'b0;
    waited      = 0;
    do begin
      cyc();
      waited++;
    end while (!acc_flag && waited < 50);
    if (!acc_flag) chk("send timeout", 32'd0, 32'd1);
    instr_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         w;
    logic [3:0] ir_seq;
    int         t0;

    // reset
    repeat (3) cyc();
    Reset_n = 1'b1;
    cyc();

    // back-to-back stream: mov, imm, flag-setting ALU op
    ex_ready = 1'b1;
    sc_in    = 1'b1;
    send(9'b1_0000_0001, w); chk("stream mov accept", 32'(w), 32'd1);
    send(9'b00111_0011,  w); chk("stream imm accept", 32'(w), 32'd1);
    send(9'b0111_010_01, w); chk("stream alu accept", 32'(w), 32'd1);
    sc_in = 1'b0;
    repeat (2) cyc();

    // EX backpressure: held word must stay put and block fetch
    ex_ready = 1'b0;
    send(9'b1_0000_0101, w);
    instr_valid = 1'b1;
    instr       = 9'b0100_011_10;
    acc_flag    = 1'b0;
    repeat (4) cyc();
    chk("hold no accept", 32'(acc_flag), 32'd0);
    ex_ready = 1'b1;
    t0 = 0;
    while (!acc_flag && t0 < 10) begin cyc(); t0++; end
    chk("hold released", 32'(acc_flag), 32'd1);
    instr_valid = 1'b0;
    repeat (2) cyc();

    // branches against sc: clear+jcnd not taken, invert+jcnd taken
    t0 = takes;
    send(9'b011011111, w);
    send(9'b00101_0110, w);
    repeat (2) cyc();
    chk("jcnd after clear", 32'(takes - t0), 32'd0);
    send(9'b011010011, w);
    send(9'b00101_0110, w);
    repeat (2) cyc();
    chk("jcnd after invert", 32'(takes - t0), 32'd1);
    chk("taken targetLUT", 32'(take_lut), 32'd6);

    // load stall shape: issue cycle, two stalled cycles, then ready again
    send(9'b00010_0011, w);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      #2;
      ir_seq[3 - k] = instr_ready;
    end
    chk("load stall pattern", 32'(ir_seq), 32'(4'b1001));
    cyc();

    // all-zero word behaves as a nop
    send(9'b000000000, w);
    repeat (2) cyc();

    // reset while waiting on a load
    send(9'b00010_0111, w);
    cyc();
    Reset_n = 1'b0;
    cyc();
    Reset_n = 1'b1;
    cyc();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (!instr_valid || acc_flag) begin
        instr_valid = ($urandom_range(0, 4) != 0);
        instr       = rand_word();
        acc_flag    = 1'b0;
      end
      ex_ready = ($urandom_range(0, 3) != 0);
      sc_in    = 1'(($urandom));
      cyc();
    end
    instr_valid = 1'b0;
    ex_ready    = 1'b1;
    repeat (6) cyc();
    chk("scoreboard drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
